quad_step_ctrl: RTL

//   Front-end control stage for the 10-bit load/up-down counter: turns a raw

---
 rtl/quad_step_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/quad_step_ctrl.sv
// rtl/quad_step_ctrl.sv - quadrature encoder and load button front end driving the up/down counter strobes
module quad_step_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 5000,
    parameter int X4          = 1
) (
    input  logic clk5m,
    input  logic rst,
    input  logic enc_a,
    input  logic enc_b,
    input  logic btn_load,
    output logic en,
    output logic updn,
    output logic load,
    output logic err
);
    localparam int CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int SETTLE = SYNC_STAGES + DB_CYCLES;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE);

    // Channel packing used throughout: bit 0 = A, bit 1 = B, bit 2 = button.
    logic [2:0]        sync_q [SYNC_STAGES];
    logic [2:0]        sync_v;
    logic [2:0]        deb;
    logic [2:0]        prev;
    logic [CW-1:0]     db_cnt [3];
    logic [SW-1:0]     settle_cnt;
    logic signed [3:0] acc;
    logic signed [3:0] acc_next;
    logic              settling;
    logic              ab_chg;
    logic              ab_both;
    logic              step_dn;

    assign sync_v   = sync_q[SYNC_STAGES-1];
    assign settling = (settle_cnt != SETTLE_END);
    assign ab_chg   = (deb[1:0] != prev[1:0]);
    assign ab_both  = &(deb[1:0] ^ prev[1:0]);
    // For a single-bit Gray step, old A xor new B is 1 exactly on a down step.
    assign step_dn  = prev[0] ^ deb[1];
    assign acc_next = step_dn ? (acc - 4'sd1) : (acc + 4'sd1);

    always_ff @(posedge clk5m) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
            deb        <= '0;
            prev       <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            en         <= 1'b0;
            updn       <= 1'b0;
            load       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sync_q[0] <= {btn_load, enc_b, enc_a};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            en   <= 1'b0;
            load <= 1'b0;
            err  <= 1'b0;

            if (settling) begin
                // prev tracks too, so the first live cycle sees no phantom edge
                settle_cnt <= settle_cnt + SW'(1);
                deb        <= sync_v;
                prev       <= sync_v;
                for (int i = 0; i < 3; i++) begin
                    db_cnt[i] <= '0;
                end
            end else begin
                prev <= deb;
                for (int i = 0; i < 3; i++) begin
                    if (sync_v[i] != deb[i]) begin
                        if (db_cnt[i] == CNT_LAST) begin
                            deb[i]    <= sync_v[i];
                            db_cnt[i] <= '0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + CW'(1);
                        end
                    end else begin
                        db_cnt[i] <= '0;
                    end
                end

                load <= deb[2] & ~prev[2];

                if (ab_chg) begin
                    if (ab_both) begin
                        err <= 1'b1;
                        if (X4 == 0) begin
                            acc <= '0;
                        end
                    end else if (X4 != 0) begin
                        en   <= 1'b1;
                        updn <= step_dn;
                    end else if (acc_next == 4'sd4) begin
                        en   <= 1'b1;
                        updn <= 1'b0;
                        acc  <= '0;
                    end else if (acc_next == -4'sd4) begin
                        en   <= 1'b1;
                        updn <= 1'b1;
                        acc  <= '0;
                    end else begin
                        acc <= acc_next;
                    end
                end
            end
        end
    end
endmodule
